// File: rtl/divider_if.sv
// divider_if: operand, function-code and result signals between ALU control and the divider.
interface divider_if;
   logic [31:0] dataA;
   logic [31:0] dataB;
   logic [5:0]  Signal;
   logic        start;
   logic [63:0] dataOut;
   logic        busy;
   logic        done;
   logic        divByZero;
   modport master (output dataA, dataB, Signal, start, input dataOut, busy, done, divByZero);
   modport slave  (input dataA, dataB, Signal, start, output dataOut, busy, done, divByZero);
endinterface

// File: rtl/divider.sv
// divider: 32-bit unsigned restoring divider, one quotient bit per clock, result {rem, quo}.
module divider (
   input  logic      clk,
   input  logic      reset,
   divider_if.slave  bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   localparam logic [5:0] DIVU = 6'b011011;
   logic [1:0]  state;
   logic [31:0] quo, rem, div;
   logic [4:0]  count;
   logic [63:0] res;
   logic        dbz;
   logic [32:0] t, diff;
   logic        ge, accept;
   logic [31:0] rem_n, quo_n;
   // 33-bit compare/subtract so the shifted partial remainder never overflows
   always_comb begin
      t      = {rem, quo[31]};
      diff   = t - {1'b0, div};
      ge     = t >= {1'b0, div};
      rem_n  = ge ? diff[31:0] : t[31:0];
      quo_n  = {quo[30:0], ge};
      accept = bus.start && bus.Signal == DIVU && state != RUN;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         quo   <= '0;
         rem   <= '0;
         div   <= '0;
         count <= '0;
         res   <= '0;
         dbz   <= 1'b0;
      end else if (accept) begin
         state <= RUN;
         quo   <= bus.dataA;
         rem   <= '0;
         div   <= bus.dataB;
         count <= '0;
         dbz   <= bus.dataB == '0;
      end else if (state == RUN) begin
         quo   <= quo_n;
         rem   <= rem_n;
         count <= count + 5'd1;
         if (count == 5'd31) begin
            state <= DONE;
            res   <= {rem_n, quo_n};
         end
      end else if (state == DONE) begin
         state <= IDLE;
      end
   end
   // the published result only changes at completion, so it holds through RUN
   assign bus.dataOut   = res;
   assign bus.busy      = state == RUN;
   assign bus.done      = state == DONE;
   assign bus.divByZero = dbz;
endmodule
